poly_result_unloader: RTL and testbench
=======================================

// Module: poly_result_unloader
// PURPOSE
//  Reader side of the poly_multi_v5 result interface. Detects the multiplier's o_done,
//  captures the wide o_sum_one/o_sum_mone buses, and forms c[k] = (sum_one[k] - sum_mone[k]) mod Q.
//  Streams the N coefficients, index 0 first, over a valid/ready handshake to the downstream LAC encode/compress logic.
//  Capturing the results lets the multiplier be reset or restarted while the stream drains.
// PARAMETERS
//  WIDTH  8    bits per coefficient (same as the multiplier's coefficient width)
//  N      512  coefficients per polynomial
//  Q      251  modulus; Q < 2**WIDTH
//  IDX_W  9    index width, = clog2(N)
// PORTS
//  i_clock     in   1          system clock, rising edge
//  i_reset     in   1          asynchronous, active-high reset
//  i_done      in   1          multiplier o_done (level; stays high after completion)
//  i_sum_one   in   WIDTH*N    multiplier o_sum_one; coef k at bits [k*WIDTH +: WIDTH]
//  i_sum_mone  in   WIDTH*N    multiplier o_sum_mone; same packing
//  o_coef      out  WIDTH      reduced coefficient c[o_index]
//  o_index     out  IDX_W      index of the coefficient on o_coef
//  o_valid     out  1          beat valid
//  i_ready     in   1          downstream accepts the beat when o_valid & i_ready
//  o_last      out  1          high with o_valid on index N-1
//  o_busy      out  1          high from capture through the final accepted beat
//  o_finished  out  1          one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  - Reset (async): state=IDLE; o_valid, o_last, o_busy, o_finished, o_index, o_coef = 0;
//    the done-edge register done_d is set to 1. A done level that is already high at reset
//    release does not trigger; a real 0->1 edge is required.
//  - Trigger: start = i_done & ~done_d & (state==IDLE). done_d <= i_done every cycle.
//  - FSM: IDLE -> STREAM on start. STREAM -> FIN when the beat with index N-1 is accepted.
//    FIN -> IDLE after one cycle.
//  - Capture:
//    - On the start edge, load i_sum_one and i_sum_mone into two WIDTH*N shift buffers.
//    - Set o_index=0 and o_busy=1.
//    - o_valid=1 from the next cycle; latency from the edge sampling i_done=1 to the first valid is 1 cycle.
//  - Output: o_coef is computed from the low WIDTH bits of each buffer (a, b):
//    - d = {1'b0,a} - {1'b0,b}, a (WIDTH+1)-bit signed value.
//    - If d < 0, r = d + Q; otherwise r = d.
//    - If r >= Q, subtract Q once.
//    - All three steps are modulo 2**WIDTH. Inputs are < Q; out-of-range inputs still give this deterministic result.
//  - Handshake: in STREAM, o_valid stays 1. When o_valid & ~i_ready, o_coef, o_index and o_last
//    hold stable. On accept (o_valid & i_ready), both buffers shift right by WIDTH and o_index increments.
//    Full rate is one beat per cycle.
//  - o_last = o_valid & (o_index == N-1).
//  - On the last accept: o_valid=0, o_busy=0, o_finished=1 for exactly one cycle (FIN).
//    o_index returns to 0.
//  - i_done edges while in STREAM or FIN are ignored, and i_sum_* changes there have no effect.
//    A new start needs i_done to go low and then high again, with state IDLE.
//  - A rising edge on i_done in the FIN cycle is lost; upstream guarantees this does not happen.
//  - Reset mid-stream: the stream is aborted immediately and all outputs take their reset values.
//    There is no partial resume.
// TESTING
//  1 sum_one[k]=k mod 251, sum_mone=0, i_ready=1, 0->1 edge on i_done
//    -> first valid 1 cycle later; 512 consecutive beats with o_coef=k mod 251 and o_index=k.
//    -> o_last only at k=511; o_finished pulse on the next cycle.
//  2 sum_one=3, sum_mone=10 for all k -> every o_coef=244.
//    sum_one=250, sum_mone=0 -> 250. sum_one=0, sum_mone=250 -> 1. Equal values -> 0.
//  3 Pattern from test 1 with i_ready pseudo-random (~50%) -> same 512-value sequence, none dropped or duplicated.
//    -> o_coef/o_index/o_last stable on every stalled cycle; total beats = 512.
//  4 i_done held high after the stream -> no second stream. Drop i_done, raise it with a new pattern
//    -> the new pattern streams correctly. i_done already high at reset release -> no stream.
//  5 Assert i_reset while index 100 is being accepted -> outputs zero at once; no beats after release
//    until a fresh i_done edge, which streams from index 0.
//  6 Change i_sum_* and pulse i_done mid-stream -> the original captured values continue unaffected.

Source files
------------

// File: rtl/poly_result_unloader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | poly_result_unloader: captures poly multiplier results and streams      |
// | c[k] = (sum_one[k] - sum_mone[k]) mod Q over valid/ready.  Rev 1.0      |
// +-------------------------------------------------------------------------+
module poly_result_unloader #(
  parameter int WIDTH = 8,
  parameter int N     = 512,
  parameter int Q     = 251,
  parameter int IDX_W = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_done,
  input  logic [WIDTH*N-1:0] i_sum_one,
  input  logic [WIDTH*N-1:0] i_sum_mone,
  output logic [WIDTH-1:0]   o_coef,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_finished
);

  localparam logic [WIDTH-1:0] c_q        = WIDTH'(Q);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 done_dly_q, done_dly_d;
  logic [WIDTH*N-1:0]   one_q, one_d;
  logic [WIDTH*N-1:0]   mone_q, mone_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;

  logic                 w_start;
  logic                 w_accept;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_wrap;
  logic [WIDTH-1:0]     w_coef;

  // Reduction of the current head coefficient; all arithmetic wraps at 2**WIDTH.
  always_comb begin
    w_diff = {1'b0, one_q[WIDTH-1:0]} - {1'b0, mone_q[WIDTH-1:0]};
    w_wrap = w_diff[WIDTH] ? (w_diff[WIDTH-1:0] + c_q) : w_diff[WIDTH-1:0];
    w_coef = (w_wrap >= c_q) ? (w_wrap - c_q) : w_wrap;
  end

  assign w_start  = i_done & ~done_dly_q & (state_q == ST_IDLE);
  assign w_accept = valid_q & i_ready;

  always_comb begin
    state_d    = state_q;
    done_dly_d = i_done;
    one_d      = one_q;
    mone_d     = mone_q;
    index_d    = index_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    finished_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          one_d   = i_sum_one;
          mone_d  = i_sum_mone;
          index_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          one_d  = one_q >> WIDTH;
          mone_d = mone_q >> WIDTH;
          if (index_q == c_last_idx) begin
            index_d    = '0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            finished_d = 1'b1;
            state_d    = ST_FIN;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // done_dly resets high so a level already asserted at release is not an edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      done_dly_q <= 1'b1;
      one_q      <= '0;
      mone_q     <= '0;
      index_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_dly_q <= done_dly_d;
      one_q      <= one_d;
      mone_q     <= mone_d;
      index_q    <= index_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
    end
  end

  assign o_coef     = w_coef;
  assign o_index    = index_q;
  assign o_valid    = valid_q;
  assign o_last     = valid_q & (index_q == c_last_idx);
  assign o_busy     = busy_q;
  assign o_finished = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_result_unloader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_poly_result_unloader: directed self-checking bench for the unloader. |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_poly_result_unloader;

  localparam int WIDTH = 8;
  localparam int N     = 512;
  localparam int Q     = 251;
  localparam int IDX_W = 9;

  logic               clk;
  logic               rst;
  logic               i_done;
  logic [WIDTH*N-1:0] i_sum_one;
  logic [WIDTH*N-1:0] i_sum_mone;
  logic [WIDTH-1:0]   o_coef;
  logic [IDX_W-1:0]   o_index;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;
  logic               o_busy;
  logic               o_finished;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_c [N];

  poly_result_unloader #(
    .WIDTH(WIDTH), .N(N), .Q(Q), .IDX_W(IDX_W)
  ) u_dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_done     (i_done),
    .i_sum_one  (i_sum_one),
    .i_sum_mone (i_sum_mone),
    .o_coef     (o_coef),
    .o_index    (o_index),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_finished (o_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected coefficients are hand-computed constants per pattern.
  task automatic set_pat(input int kind);
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: begin i_sum_one[k*WIDTH +: WIDTH] = 8'(k % 251); i_sum_mone[k*WIDTH +: WIDTH] = 8'd0;   exp_c[k] = 8'(k % 251); end
        1: begin i_sum_one[k*WIDTH +: WIDTH] = 8'd3;        i_sum_mone[k*WIDTH +: WIDTH] = 8'd10;  exp_c[k] = 8'd244; end
        2: begin i_sum_one[k*WIDTH +: WIDTH] = 8'd250;      i_sum_mone[k*WIDTH +: WIDTH] = 8'd0;   exp_c[k] = 8'd250; end
        3: begin i_sum_one[k*WIDTH +: WIDTH] = 8'd0;        i_sum_mone[k*WIDTH +: WIDTH] = 8'd250; exp_c[k] = 8'd1;   end
        default: begin i_sum_one[k*WIDTH +: WIDTH] = 8'd77; i_sum_mone[k*WIDTH +: WIDTH] = 8'd77;  exp_c[k] = 8'd0;   end
      endcase
    end
  endtask

  task automatic start_stream(input int kind);
    set_pat(kind);
    i_ready = 1'b0;
    i_done  = 1'b0;
    step();
    i_done = 1'b1;
    step();
    check_val("first_valid", o_valid, 1);
    check_val("first_busy", o_busy, 1);
  endtask

  task automatic drain(input bit rand_ready, input bit disturb);
    int beats  = 0;
    int cycles = 0;
    bit rdy;
    while (beats < N && cycles < 20000) begin
      check_val("busy", o_busy, 1);
      check_val("valid", o_valid, 1);
      if (o_valid) begin
        check_val("index", o_index, beats);
        check_val("coef", o_coef, exp_c[beats]);
        check_val("last", o_last, (beats == N - 1));
      end
      if (disturb && beats == 50) i_done = 1'b0;
      if (disturb && beats == 60) begin
        i_done = 1'b1;
        for (int k = 0; k < N; k++) begin
          i_sum_one[k*WIDTH +: WIDTH]  = 8'd200;
          i_sum_mone[k*WIDTH +: WIDTH] = 8'd9;
        end
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ready = rdy;
      if (o_valid && rdy) beats++;
      step();
      cycles++;
    end
    check_val("beats", beats, N);
    i_ready = 1'b0;
    check_val("fin_pulse", o_finished, 1);
    check_val("fin_valid", o_valid, 0);
    check_val("fin_busy", o_busy, 0);
    check_val("fin_index", o_index, 0);
    step();
    check_val("fin_clear", o_finished, 0);
    check_val("idle_valid", o_valid, 0);
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      step();
      check_val(tag, o_valid, 0);
    end
  endtask

  initial begin
    int guard;
    rst        = 1'b1;
    i_done     = 1'b1;
    i_ready    = 1'b0;
    i_sum_one  = '0;
    i_sum_mone = '0;
    step();
    step();
    check_val("rst_valid", o_valid, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_index", o_index, 0);
    check_val("rst_coef", o_coef, 0);
    check_val("rst_fin", o_finished, 0);
    check_val("rst_last", o_last, 0);
    rst = 1'b0;
    expect_quiet("done_high_at_release", 10);

    start_stream(0);
    drain(1'b0, 1'b0);
    expect_quiet("done_held_high", 20);

    for (int kind = 1; kind <= 4; kind++) begin
      start_stream(kind);
      drain(1'b0, 1'b0);
    end

    start_stream(0);
    drain(1'b1, 1'b0);

    start_stream(0);
    drain(1'b1, 1'b1);

    // Abort while index 100 is being accepted.
    start_stream(0);
    i_ready = 1'b1;
    guard = 0;
    while (!(o_valid && o_index == 9'd100) && guard < 1000) begin
      step();
      guard++;
    end
    check_val("reach_idx100", o_index, 100);
    rst = 1'b1;
    #1;
    check_val("abort_valid", o_valid, 0);
    check_val("abort_index", o_index, 0);
    check_val("abort_coef", o_coef, 0);
    check_val("abort_busy", o_busy, 0);
    check_val("abort_last", o_last, 0);
    step();
    step();
    rst = 1'b0;
    expect_quiet("after_abort", 10);
    start_stream(3);
    drain(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
